// File: rtl/rename_pkg.sv
// Rename-stage shared types: physical/architectural register counts and the tag type.
// Used by the free list, RAT and ROB.
package rename_pkg;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PREG_W        = $clog2(NUM_PHYS_REGS);

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical tags with a speculative and a committed head.
// Optional FL_BYPASS_EN: a tag freed while the list is empty is offered directly at alloc_preg.
module rename_freelist
    import rename_pkg::*;
(
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           alloc_req,
    output preg_t                                          alloc_preg,
    output logic                                           fl_empty,
    input  logic                                           free_valid,
    input  preg_t                                          free_preg,
    input  logic                                           commit_alloc,
    input  logic                                           flush,
    output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0]   fl_count,
    output logic                                           free_err
);

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W:0] ptr_t;

    preg_t r_entry [DEPTH];
    ptr_t  r_spec_head;
    ptr_t  r_arch_head;
    ptr_t  r_tail;
    logic  r_free_err;

    ptr_t  w_count;
    ptr_t  w_arch_next;
    logic  w_empty_raw;
    logic  w_full;
    logic  w_alloc;
    logic  w_free_ok;
    logic  w_bypass_take;
    logic  w_write;
    preg_t w_head_tag;

    assign w_count     = r_tail - r_spec_head;
    assign w_empty_raw = (w_count == '0);
    assign w_full      = (w_count == ptr_t'(DEPTH));
    assign w_arch_next = r_arch_head + ptr_t'(commit_alloc);
    assign w_head_tag  = r_entry[r_spec_head[PTR_W-1:0]];

    // Flush makes the head non-speculative, so a same-cycle alloc is dropped.
    assign w_alloc   = alloc_req && !flush && !w_empty_raw;
    // A full list still accepts a free when the same edge pops a tag.
    assign w_free_ok = free_valid && (!w_full || w_alloc);

`ifdef FL_BYPASS_EN
    logic w_bypass;
    assign w_bypass      = w_empty_raw && free_valid;
    assign w_bypass_take = w_bypass && alloc_req && !flush;
    always_comb begin
        alloc_preg = w_bypass ? free_preg : w_head_tag;
        fl_empty   = w_empty_raw && !free_valid;
    end
`else
    assign w_bypass_take = 1'b0;
    always_comb begin
        alloc_preg = w_head_tag;
        fl_empty   = w_empty_raw;
    end
`endif

    // A bypassed tag never touches the array or the tail.
    assign w_write  = w_free_ok && !w_bypass_take;
    assign fl_count = w_count;
    assign free_err = r_free_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spec_head <= '0;
            r_arch_head <= '0;
            r_tail      <= ptr_t'(DEPTH);
            r_free_err  <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every pointer sees pre-edge values of the others.
            r_arch_head <= w_arch_next;
            if (flush)
                r_spec_head <= w_arch_next;
            else if (w_alloc)
                r_spec_head <= r_spec_head + ptr_t'(1);
            if (w_write)
                r_tail <= r_tail + ptr_t'(1);
            if (free_valid && !w_free_ok)
                r_free_err <= 1'b1;
        end
    end

    // NOTE: the array must be reset because its contents define the initial free tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_entry[i] <= preg_t'(NUM_ARCH_REGS + i);
        end else if (w_write) begin
            r_entry[r_tail[PTR_W-1:0]] <= free_preg;
        end
    end

    function automatic logic f_on_list(input preg_t tag);
        logic [PTR_W-1:0] idx;
        logic             hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_spec_head[PTR_W-1:0] + PTR_W'(i);
            if ((ptr_t'(i) < w_count) && (r_entry[idx] == tag))
                hit = 1'b1;
        end
        return hit;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(commit_alloc && (r_arch_head == r_spec_head)))
                else $error("committed head passed speculative head");
            assert (!(w_write && f_on_list(free_preg)))
                else $error("tag freed while already on the free list");
        end
    end

endmodule

// File: tb/tb_rename_freelist.sv
// Self-checking bench for rename_freelist: vector table plus a queue-based free-list model.
module tb_rename_freelist;
    import rename_pkg::*;

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_req;
    preg_t            alloc_preg;
    logic             fl_empty;
    logic             free_valid;
    preg_t            free_preg;
    logic             commit_alloc;
    logic             flush;
    logic [PTR_W:0]   fl_count;
    logic             free_err;

    rename_freelist dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_preg   (alloc_preg),
        .fl_empty     (fl_empty),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .commit_alloc (commit_alloc),
        .flush        (flush),
        .fl_count     (fl_count),
        .free_err     (free_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int fl_q[$];
    int spec_q[$];
    int sb_q[$];

    typedef struct {
        bit rst;
        int rep;
        bit a;
        bit f;
        int tag;
        bit c;
        bit fl;
        int e_cnt;
        bit e_empty;
        int e_preg;
        bit e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        fl_q.delete();
        spec_q.delete();
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++)
            fl_q.push_back(NUM_ARCH_REGS + i);
    endfunction

    function automatic bit model_bypass(input bit a, input bit f, input bit fl);
`ifdef FL_BYPASS_EN
        return a && f && !fl && (fl_q.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_edge(input bit a, input bit f, input int tag,
                                       input bit c, input bit fl);
        int cnt;
        bit aok;
        bit fok;
        bit byp;
        cnt = fl_q.size();
        aok = a && !fl && (cnt > 0);
        byp = model_bypass(a, f, fl);
        fok = f && ((cnt - int'(aok)) < DEPTH);
        if (aok)
            spec_q.push_back(fl_q.pop_front());
        if (c && (spec_q.size() > 0))
            void'(spec_q.pop_front());
        if (fl)
            while (spec_q.size() > 0)
                fl_q.push_front(spec_q.pop_back());
        if (fok && !byp)
            fl_q.push_back(tag);
    endfunction

    task automatic clear_inputs();
        alloc_req    = 1'b0;
        free_valid   = 1'b0;
        free_preg    = '0;
        commit_alloc = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit a, input bit f, input int tag, input bit c, input bit fl);
        alloc_req    = a;
        free_valid   = f;
        free_preg    = preg_t'(tag);
        commit_alloc = c;
        flush        = fl;
        if (a && !fl && (fl_q.size() > 0))
            sb_q.push_back(fl_q[0]);
        else if (model_bypass(a, f, fl))
            sb_q.push_back(tag);
        #1;
        if (sb_q.size() > 0)
            check("alloc_tag", int'(alloc_preg), sb_q.pop_front());
        @(posedge clk);
        model_edge(a, f, tag, c, fl);
        @(negedge clk);
        clear_inputs();
        #1;
        check("model_count", int'(fl_count), fl_q.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_count", int'(fl_count), 32);
        check("rst_empty", int'(fl_empty), 0);
        check("rst_preg",  int'(alloc_preg), 32);
        check("rst_err",   int'(free_err), 0);

        for (int i = 0; i < DEPTH; i++) begin
            check("seq_tag", int'(alloc_preg), 32 + i);
            step(1, 0, 0, 0, 0);
            check("seq_count", int'(fl_count), 31 - i);
        end
        check("drain_empty", int'(fl_empty), 1);
        step(1, 0, 0, 0, 0);
        check("over_alloc_count", int'(fl_count), 0);
        check("over_alloc_empty", int'(fl_empty), 1);

        //                rst rep a  f  tag c  fl cnt emp preg err
        tbl.push_back(vec_t'{0, 1, 0, 1,  5, 0, 0,  1, 0,  5, 0});
        tbl.push_back(vec_t'{0, 1, 0, 1,  7, 0, 0,  2, 0,  5, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0,  0, 0, 0,  1, 0,  7, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0,  0, 0, 0,  0, 1, -1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0,  0, 0, 0, 32, 0, 32, 0});
        tbl.push_back(vec_t'{0,22, 1, 0,  0, 0, 0, 10, 0, 54, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 40, 0, 0, 10, 0, 55, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 41, 0, 0, 10, 0, 56, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 42, 0, 0, 10, 0, 57, 0});
        tbl.push_back(vec_t'{0, 7, 1, 0,  0, 0, 0,  3, 0, 40, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0,  0, 0, 0,  2, 0, 41, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0,  0, 0, 0,  1, 0, 42, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0,  0, 0, 0,  0, 1, -1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0,  0, 0, 0, 32, 0, 32, 0});
        tbl.push_back(vec_t'{0, 4, 1, 0,  0, 0, 0, 28, 0, 36, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0,  0, 1, 0, 28, 0, 36, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0,  0, 0, 1, 31, 0, 33, 0});
        tbl.push_back(vec_t'{0, 2, 1, 0,  0, 0, 0, 29, 0, 35, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 10, 0, 1, 32, 0, 33, 0});
        tbl.push_back(vec_t'{0, 1, 0, 1,  3, 0, 0, 32, 0, 33, 1});
        tbl.push_back(vec_t'{0, 1, 0, 0,  0, 0, 0, 32, 0, 33, 1});
        tbl.push_back(vec_t'{0, 1, 1, 1,  3, 0, 0, 32, 0, 34, 1});
        tbl.push_back(vec_t'{1, 0, 0, 0,  0, 0, 0, 32, 0, 32, 0});
        tbl.push_back(vec_t'{0, 3, 1, 0,  0, 0, 0, 29, 0, 35, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0,  0, 1, 1, 31, 0, 33, 0});
        tbl.push_back(vec_t'{0,31, 1, 0,  0, 0, 0,  0, 1, -1, 0});

        foreach (tbl[k]) begin
            if (tbl[k].rst)
                do_reset();
            else
                for (int r = 0; r < tbl[k].rep; r++)
                    step(tbl[k].a, tbl[k].f, tbl[k].tag, tbl[k].c, tbl[k].fl);
            check($sformatf("v%0d_count", k), int'(fl_count), tbl[k].e_cnt);
            check($sformatf("v%0d_empty", k), int'(fl_empty), int'(tbl[k].e_empty));
            if (tbl[k].e_preg >= 0)
                check($sformatf("v%0d_preg", k), int'(alloc_preg), tbl[k].e_preg);
            check($sformatf("v%0d_err", k), int'(free_err), int'(tbl[k].e_err));
        end

        // Empty list: free and alloc in the same cycle.
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_preg  = preg_t'(9);
        #1;
`ifdef FL_BYPASS_EN
        check("byp_empty_in_cycle", int'(fl_empty), 0);
        check("byp_preg_in_cycle",  int'(alloc_preg), 9);
`else
        check("nobyp_empty_in_cycle", int'(fl_empty), 1);
`endif
        check("empty_count_in_cycle", int'(fl_count), 0);
        @(posedge clk);
        model_edge(1, 1, 9, 0, 0);
        @(negedge clk);
        clear_inputs();
        #1;
`ifdef FL_BYPASS_EN
        check("byp_count_after", int'(fl_count), 0);
        check("byp_empty_after", int'(fl_empty), 1);
`else
        check("nobyp_count_after", int'(fl_count), 1);
        check("nobyp_preg_after",  int'(alloc_preg), 9);
`endif
        check("empty_model_after", int'(fl_count), fl_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
